freed_reg_release_queue: RTL and testbench

//  Buffers physical registers released at commit (the previous mappings of retiring dests) and feeds them to the speculative free list.

---
 rtl/freed_reg_release_queue.sv | 141 ++++++++++++++
 tb/tb_freed_reg_release_queue.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/freed_reg_release_queue.sv
// Commit-side release queue: packs sparse freed physical registers into an in-order ring
// and drains up to DRAIN_W per cycle through a registered stage. Optional counters: FREE_RELQ_PERF_EN.
module freed_reg_release_queue #(
  parameter int COMMIT_W  = 4,
  parameter int DRAIN_W   = 2,
  parameter int PHYS_LOG  = 7,
  parameter int DEPTH     = 8,
  parameter int DEPTH_LOG = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [COMMIT_W-1:0]           freedValid_i,
  input  logic [COMMIT_W*PHYS_LOG-1:0]  freedReg_i,
  output logic                          stall_o,
  output logic [DRAIN_W-1:0]            relValid_o,
  output logic [DRAIN_W*PHYS_LOG-1:0]   relReg_o,
  output logic [DEPTH_LOG:0]            count_o
`ifdef FREE_RELQ_PERF_EN
  ,
  output logic [DEPTH_LOG:0]            hwm_o,
  output logic [31:0]                   stallCycles_o
`endif
);

  localparam int CNT_W  = DEPTH_LOG + 1;
  localparam int PC_W   = $clog2(COMMIT_W + 1);
  localparam int LANE_W = (COMMIT_W > 1) ? $clog2(COMMIT_W) : 1;

  typedef logic [PHYS_LOG-1:0] preg_t;

  preg_t                       mem_q   [DEPTH];
  preg_t                       mem_d   [DEPTH];
  logic [DEPTH_LOG-1:0]        head_q, head_d;
  logic [DEPTH_LOG-1:0]        tail_q, tail_d;
  logic [CNT_W-1:0]            count_q, count_d;
  logic [DRAIN_W-1:0]          rel_valid_q, rel_valid_d;
  logic [DRAIN_W*PHYS_LOG-1:0] rel_reg_q, rel_reg_d;

  logic                        stall;
  preg_t                       in_pack [COMMIT_W];
  logic [PC_W-1:0]             in_cnt;
  int                          deq_n, take_n, enq_n, src;

  // Depends only on registered occupancy, so commit sees it early in the cycle.
  assign stall = (count_q > CNT_W'(DEPTH - COMMIT_W));

  // Squeeze out invalid lanes; lanes offered during a stall are dropped here.
  always_comb begin
    // NOTE: every combinational output gets a default before any condition, so no latch can be inferred.
    in_cnt = '0;
    for (int i = 0; i < COMMIT_W; i++) in_pack[i] = '0;
    for (int i = 0; i < COMMIT_W; i++) begin
      if (freedValid_i[i] && !stall) begin
        in_pack[LANE_W'(in_cnt)] = freedReg_i[i*PHYS_LOG +: PHYS_LOG];
        in_cnt                   = in_cnt + PC_W'(1);
      end
    end
  end

  // Output stage takes queued entries first, then the oldest incoming lanes; the rest are enqueued.
  always_comb begin
    // NOTE: blocking assignments in combinational logic, non-blocking only in clocked processes.
    src         = 0;
    deq_n       = (int'(count_q) > DRAIN_W) ? DRAIN_W : int'(count_q);
    take_n      = ((DRAIN_W - deq_n) < int'(in_cnt)) ? (DRAIN_W - deq_n) : int'(in_cnt);
    enq_n       = int'(in_cnt) - take_n;
    rel_valid_d = '0;
    rel_reg_d   = '0;
    for (int j = 0; j < DRAIN_W; j++) begin
      src = j - deq_n;
      if (j < deq_n) begin
        rel_valid_d[j]                    = 1'b1;
        rel_reg_d[j*PHYS_LOG +: PHYS_LOG] = mem_q[head_q + DEPTH_LOG'(j)];
      end else if (src < int'(in_cnt)) begin
        rel_valid_d[j]                    = 1'b1;
        rel_reg_d[j*PHYS_LOG +: PHYS_LOG] = in_pack[LANE_W'(src)];
      end
    end

    // A slot being dequeued this cycle may be rewritten: the read above used the old contents.
    mem_d = mem_q;
    for (int k = 0; k < COMMIT_W; k++) begin
      if (k < enq_n) mem_d[tail_q + DEPTH_LOG'(k)] = in_pack[LANE_W'(take_n + k)];
    end

    head_d  = head_q + DEPTH_LOG'(deq_n);
    tail_d  = tail_q + DEPTH_LOG'(enq_n);
    count_d = count_q + CNT_W'(enq_n) - CNT_W'(deq_n);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      rel_valid_q <= '0;
      rel_reg_q   <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      rel_valid_q <= rel_valid_d;
      rel_reg_q   <= rel_reg_d;
    end
  end

  // NOTE: the storage array has no reset; head, tail and count alone decide which slots are live.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign stall_o    = stall;
  assign relValid_o = rel_valid_q;
  assign relReg_o   = rel_reg_q;
  assign count_o    = count_q;

`ifdef FREE_RELQ_PERF_EN
  logic [CNT_W-1:0] hwm_q, hwm_d;
  logic [31:0]      stall_cycles_q, stall_cycles_d;

  always_comb begin
    hwm_d          = (count_q > hwm_q) ? count_q : hwm_q;
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hwm_q          <= '0;
      stall_cycles_q <= '0;
    end else begin
      hwm_q          <= hwm_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign hwm_o         = hwm_q;
  assign stallCycles_o = stall_cycles_q;
`endif

endmodule

// File: tb/tb_freed_reg_release_queue.sv
// Scoreboard bench for freed_reg_release_queue: a FIFO-of-ids reference model predicts each
// cycle's output stage; a separate monitor pops and compares after every clock edge.
module tb_freed_reg_release_queue;

  localparam int COMMIT_W  = 4;
  localparam int DRAIN_W   = 2;
  localparam int PHYS_LOG  = 7;
  localparam int DEPTH     = 8;
  localparam int DEPTH_LOG = 3;

  logic                         clk = 1'b0;
  logic                         reset = 1'b1;
  logic [COMMIT_W-1:0]          freedValid_i = '0;
  logic [COMMIT_W*PHYS_LOG-1:0] freedReg_i = '0;
  logic                         stall_o;
  logic [DRAIN_W-1:0]           relValid_o;
  logic [DRAIN_W*PHYS_LOG-1:0]  relReg_o;
  logic [DEPTH_LOG:0]           count_o;
`ifdef FREE_RELQ_PERF_EN
  logic [DEPTH_LOG:0]           hwm_o;
  logic [31:0]                  stallCycles_o;
`endif

  freed_reg_release_queue #(
    .COMMIT_W(COMMIT_W), .DRAIN_W(DRAIN_W), .PHYS_LOG(PHYS_LOG),
    .DEPTH(DEPTH), .DEPTH_LOG(DEPTH_LOG)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .freedValid_i (freedValid_i),
    .freedReg_i   (freedReg_i),
    .stall_o      (stall_o),
    .relValid_o   (relValid_o),
    .relReg_o     (relReg_o),
    .count_o      (count_o)
`ifdef FREE_RELQ_PERF_EN
    ,
    .hwm_o        (hwm_o),
    .stallCycles_o(stallCycles_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DRAIN_W-1:0]          v;
    logic [DRAIN_W*PHYS_LOG-1:0] r;
    int                          cnt;
    bit                          stall;
    int                          hwm;
    longint                      sc;
  } exp_t;

  exp_t   exp_q[$];
  int     pend[$];          // ids accepted but not yet moved to the output stage
  int     hwm_m = 0;
  longint sc_m = 0;
  int     next_id = 0;
  int     model_released = 0;
  int     dut_released = 0;
  int     n_checks = 0;
  int     n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the output stage always holds the first DRAIN_W ids of (pending ++ accepted incoming).
  task automatic drive(input logic rst, input logic [COMMIT_W-1:0] v,
                       input logic [COMMIT_W*PHYS_LOG-1:0] regs);
    exp_t e;
    bit   stalled;
    @(negedge clk);
    reset        = rst;
    freedValid_i = v;
    freedReg_i   = regs;
    e.v = '0; e.r = '0; e.cnt = 0; e.stall = 0; e.hwm = 0; e.sc = 0;
    if (rst) begin
      pend.delete();
      hwm_m = 0;
      sc_m  = 0;
    end else begin
      stalled = (pend.size() > DEPTH - COMMIT_W);
      if (pend.size() > hwm_m) hwm_m = pend.size();
      if (stalled) sc_m++;
      if (!stalled)
        for (int i = 0; i < COMMIT_W; i++)
          if (v[i]) pend.push_back(int'(regs[i*PHYS_LOG +: PHYS_LOG]));
      for (int j = 0; j < DRAIN_W; j++) begin
        if (pend.size() > 0) begin
          e.v[j] = 1'b1;
          e.r[j*PHYS_LOG +: PHYS_LOG] = PHYS_LOG'(pend.pop_front());
          model_released++;
        end
      end
      e.cnt   = pend.size();
      e.stall = (pend.size() > DEPTH - COMMIT_W);
      e.hwm   = hwm_m;
      e.sc    = sc_m;
    end
    exp_q.push_back(e);
  endtask

  // Fresh sequential ids on valid lanes, random junk on idle lanes.
  task automatic gen(input logic [COMMIT_W-1:0] v, input logic rst);
    logic [COMMIT_W*PHYS_LOG-1:0] regs;
    for (int i = 0; i < COMMIT_W; i++) begin
      if (v[i]) begin
        regs[i*PHYS_LOG +: PHYS_LOG] = PHYS_LOG'(next_id);
        next_id = (next_id + 1) % (1 << PHYS_LOG);
      end else begin
        regs[i*PHYS_LOG +: PHYS_LOG] = PHYS_LOG'($urandom);
      end
    end
    drive(rst, v, regs);
  endtask

  // Monitor: compare the DUT output stage with the next scoreboard entry after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("relValid", 64'(relValid_o), 64'(e.v));
        check("relReg",   64'(relReg_o),   64'(e.r));
        check("count",    64'(count_o),    64'(e.cnt));
        check("stall",    64'(stall_o),    64'(e.stall));
        check("thermometer", 64'(relValid_o == 2'b00 || relValid_o == 2'b01 || relValid_o == 2'b11), 64'd1);
`ifdef FREE_RELQ_PERF_EN
        check("hwm",         64'(hwm_o),         64'(e.hwm));
        check("stallCycles", 64'(stallCycles_o), 64'(e.sc));
`endif
        for (int j = 0; j < DRAIN_W; j++) if (relValid_o[j] === 1'b1) dut_released++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [COMMIT_W-1:0] v;
    bit heavy;

    drive(1'b1, '0, '0);
    drive(1'b1, '0, '0);

    // Sparse lanes bypass straight to the output stage.
    drive(1'b0, 4'b0101, {7'd99, 7'd12, 7'd98, 7'd10});
    drive(1'b0, 4'b0000, '0);

    // Full-width burst then idle: two cycles of release.
    drive(1'b0, 4'b1111, {7'd23, 7'd22, 7'd21, 7'd20});
    drive(1'b0, 4'b0000, '0);
    drive(1'b0, 4'b0000, '0);

    // Gapped lanes are squeezed.
    gen(4'b1010, 1'b0);
    gen(4'b1001, 1'b0);
    gen(4'b0000, 1'b0);

    // Saturate: lanes offered while stalled must vanish.
    for (int c = 0; c < 10; c++) gen(4'b1111, 1'b0);
    // Drain with wrap past the top slot.
    for (int c = 0; c < 6; c++) gen(4'b0000, 1'b0);

    // Reset with five entries queued.
    gen(4'b1111, 1'b0);
    gen(4'b1111, 1'b0);
    gen(4'b0111, 1'b0);
    gen(4'b0000, 1'b1);
    for (int c = 0; c < 3; c++) gen(4'b0000, 1'b0);

    // Randomised phases, mostly respecting the model's stall, occasionally probing it.
    for (int c = 0; c < 10000; c++) begin
      heavy = ((c / 150) % 2) == 0;
      v = heavy ? COMMIT_W'($urandom | $urandom) : COMMIT_W'($urandom & $urandom);
      if ((pend.size() > DEPTH - COMMIT_W) && ($urandom_range(0, 7) != 0)) v = '0;
      gen(v, (c == 5000) ? 1'b1 : 1'b0);
    end

    for (int c = 0; c < 8; c++) gen(4'b0000, 1'b0);
    @(posedge clk);
    #2;
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    check("released_total", 64'(dut_released), 64'(model_released));
    check("model_pending", 64'(pend.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
